// File: rtl/adder_tree_pipe.sv
// Two-stage pipelined N-operand adder with carry-in, valid/ready handshake
// and an optional saturating/wrapping accumulator.
module adder_tree_pipe #(
    parameter int W   = 8,
    parameter int N   = 4,
    parameter int AW  = W + $clog2(N) + 1,
    parameter bit SAT = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N*W:0]   ins,
    input  logic           acc_mode,
    input  logic           acc_clr,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [AW-1:0]  sum,
    output logic           sum_zero,
    output logic           ovf
);

    localparam int NP = (N + 1) / 2;
    localparam int SW = W + $clog2(N) + 1;

    logic            rdy_q;
    logic            ready1;
    logic            ready2;

    logic [W:0]      p_n [NP];
    logic [W:0]      p1  [NP];
    logic            v1;
    logic            cin1;
    logic            mode1;
    logic            clr1;

    logic [SW-1:0]   s;
    logic [AW-1:0]   acc;
    logic [AW-1:0]   base;
    logic [AW:0]     acc_t;
    logic [AW-1:0]   acc_n;
    logic            ovf_n;
    logic            add_of;
    logic [AW-1:0]   sum_n;

    // Holds in_ready low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdy_q <= 1'b0;
        else        rdy_q <= 1'b1;
    end

    assign ready2   = ~out_valid | out_ready;
    assign ready1   = ~v1 | ready2;
    assign in_ready = ready1 & rdy_q;

    // Stage 1: pair-wise partial sums; an odd last operand passes alone.
    always_comb begin
        for (int unsigned i = 0; i < NP; i++) begin
            p_n[i] = {1'b0, ins[2*i*W +: W]};
            if (2*i + 1 < N)
                p_n[i] = p_n[i] + {1'b0, ins[(2*i+1)*W +: W]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1    <= 1'b0;
            cin1  <= 1'b0;
            mode1 <= 1'b0;
            clr1  <= 1'b0;
            for (int unsigned i = 0; i < NP; i++) p1[i] <= '0;
        end else if (ready1) begin
            v1 <= in_valid & in_ready;
            if (in_valid & in_ready) begin
                cin1  <= ins[N*W];
                mode1 <= acc_mode;
                clr1  <= acc_clr;
                for (int unsigned i = 0; i < NP; i++) p1[i] <= p_n[i];
            end
        end
    end

    // Stage 2: final reduction and accumulator update.
    always_comb begin
        s = SW'(cin1);
        for (int unsigned i = 0; i < NP; i++)
            s = s + SW'(p1[i]);

        base   = clr1 ? '0 : acc;
        acc_t  = {1'b0, base} + (AW+1)'(s);
        add_of = acc_t[AW];

        acc_n = acc;
        ovf_n = ovf;
        sum_n = AW'(s);
        if (mode1) begin
            if (add_of && SAT) acc_n = '1;
            else               acc_n = acc_t[AW-1:0];
            ovf_n = clr1 ? add_of : (ovf | add_of);
            sum_n = acc_n;
        end else if (clr1) begin
            acc_n = '0;
            ovf_n = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            sum       <= '0;
            sum_zero  <= 1'b0;
            acc       <= '0;
            ovf       <= 1'b0;
        end else if (ready2) begin
            out_valid <= v1;
            if (v1) begin
                sum      <= sum_n;
                sum_zero <= (sum_n == '0);
                acc      <= acc_n;
                ovf      <= ovf_n;
            end
        end
    end

endmodule

// File: tb/tb_adder_tree_pipe.sv
// Self-checking bench for adder_tree_pipe: directed steps plus random beats,
// compared against an arithmetic scoreboard for a saturating and a wrapping instance.
module tb_adder_tree_pipe;

    localparam int W  = 8;
    localparam int N  = 4;
    localparam int AW = 11;
    localparam longint MAXV = 2047;

    logic clk = 1'b0;
    logic rst_n;
    logic in_valid;
    logic [N*W:0] ins;
    logic acc_mode, acc_clr, out_ready;
    logic in_ready_s, out_valid_s, sum_zero_s, ovf_s;
    logic in_ready_w, out_valid_w, sum_zero_w, ovf_w;
    logic [AW-1:0] sum_s, sum_w;

    always #5 clk = ~clk;

    adder_tree_pipe #(.W(W), .N(N), .AW(AW), .SAT(1'b1)) u_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
        .ins(ins), .acc_mode(acc_mode), .acc_clr(acc_clr),
        .out_valid(out_valid_s), .out_ready(out_ready),
        .sum(sum_s), .sum_zero(sum_zero_s), .ovf(ovf_s)
    );

    adder_tree_pipe #(.W(W), .N(N), .AW(AW), .SAT(1'b0)) u_wrap (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w),
        .ins(ins), .acc_mode(acc_mode), .acc_clr(acc_clr),
        .out_valid(out_valid_w), .out_ready(out_ready),
        .sum(sum_w), .sum_zero(sum_zero_w), .ovf(ovf_w)
    );

    typedef struct {
        longint sum_s;
        logic   ovf_s;
        longint sum_w;
        logic   ovf_w;
    } exp_t;

    exp_t   q[$];
    longint m_acc_s, m_acc_w;
    logic   m_ovf_s, m_ovf_w;
    int     ncmp = 0;
    int     nfail = 0;
    int     cyc = 0;
    int     rmode = 0;
    int     nout = 0;
    bit     armed = 0;
    bit     got;
    bit     stall_prev = 0;
    logic   ov_s;
    logic [AW-1:0] held_s, held_w;

    task automatic chk(input string tag, input longint obs, input longint exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Accumulator model: plain integer arithmetic, clamp or modulo on overflow.
    task automatic model_push();
        longint s, t, base;
        logic of;
        exp_t e;
        s = longint'(ins[7:0]) + longint'(ins[15:8]) + longint'(ins[23:16])
          + longint'(ins[31:24]) + longint'(ins[32]);
        e.sum_s = s;
        e.sum_w = s;
        if (acc_mode) begin
            base = acc_clr ? 0 : m_acc_s;
            t = base + s;
            of = (t > MAXV);
            m_acc_s = of ? MAXV : t;
            m_ovf_s = acc_clr ? of : (m_ovf_s | of);
            e.sum_s = m_acc_s;
            base = acc_clr ? 0 : m_acc_w;
            t = base + s;
            of = (t > MAXV);
            m_acc_w = t % (MAXV + 1);
            m_ovf_w = acc_clr ? of : (m_ovf_w | of);
            e.sum_w = m_acc_w;
        end else if (acc_clr) begin
            m_acc_s = 0; m_ovf_s = 0;
            m_acc_w = 0; m_ovf_w = 0;
        end
        e.ovf_s = m_ovf_s;
        e.ovf_w = m_ovf_w;
        q.push_back(e);
    endtask

    // One clock cycle: sample and check at negedge, then drive after posedge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        ov_s = out_valid_s;
        if (armed) begin
            chk("in_ready", in_ready_s, !(q.size() == 2 && !out_ready));
            chk("flow_match", out_valid_w, out_valid_s);
        end
        if (stall_prev && out_valid_s) begin
            chk("hold_sum_sat", sum_s, held_s);
            chk("hold_sum_wrap", sum_w, held_w);
        end
        if (out_valid_s && out_ready) begin
            if (q.size() == 0) begin
                chk("spurious_out", out_valid_s, 0);
            end else begin
                e = q.pop_front();
                nout++;
                chk("sum_sat", sum_s, e.sum_s);
                chk("zero_sat", sum_zero_s, e.sum_s == 0);
                chk("ovf_sat", ovf_s, e.ovf_s);
                chk("sum_wrap", sum_w, e.sum_w);
                chk("zero_wrap", sum_zero_w, e.sum_w == 0);
                chk("ovf_wrap", ovf_w, e.ovf_w);
            end
        end
        if (in_valid && in_ready_s) begin
            model_push();
            got = 1;
        end
        stall_prev = out_valid_s && !out_ready;
        held_s = sum_s;
        held_w = sum_w;
        @(posedge clk);
        #1;
        cyc++;
        case (rmode)
            1: out_ready = (cyc % 3 == 0);
            2: out_ready = ($urandom % 3 != 0);
            3: out_ready = 1'b0;
            default: out_ready = 1'b1;
        endcase
    endtask

    task automatic send(input logic [7:0] a, b, c, d, input logic cin, m, clr);
        in_valid = 1'b1;
        ins      = {cin, d, c, b, a};
        acc_mode = m;
        acc_clr  = clr;
        got = 0;
        for (int k = 0; k < 100 && !got; k++) tick();
        if (!got) chk("accept_timeout", 0, 1);
    endtask

    task automatic drain();
        in_valid = 1'b0;
        for (int k = 0; k < 200 && q.size() > 0; k++) tick();
        chk("drain_empty", q.size(), 0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; ins = '0;
        acc_mode = 1'b0; acc_clr = 1'b0; out_ready = 1'b1;
        m_acc_s = 0; m_acc_w = 0; m_ovf_s = 0; m_ovf_w = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid_s, 0);
        chk("rst_sum", sum_s, 0);
        chk("rst_sum_zero", sum_zero_s, 0);
        chk("rst_ovf", ovf_s, 0);
        chk("rst_in_ready", in_ready_s, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("in_ready_before_edge", in_ready_s, 0);
        @(posedge clk);
        #1;
        chk("in_ready_after_edge", in_ready_s, 1);
        armed = 1;

        // 1: single pass-through beat and its two-edge latency
        send(8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0);
        in_valid = 1'b0;
        tick();
        chk("latency_t1", ov_s, 0);
        tick();
        chk("latency_t2", ov_s, 1);
        drain();

        // 2: zero beat then 1+2+3+4
        send(0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        send(1, 2, 3, 4, 1'b0, 1'b0, 1'b0);
        drain();

        // 3: accumulate with clear
        send(1, 1, 1, 1, 1'b0, 1'b1, 1'b1);
        send(1, 1, 1, 1, 1'b0, 1'b1, 1'b0);
        send(1, 1, 1, 1, 1'b0, 1'b1, 1'b0);
        send(2, 0, 0, 0, 1'b0, 1'b1, 1'b1);
        drain();

        // 4: 1021 x3, saturating and wrapping instances side by side
        send(8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b1);
        send(8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b0);
        send(8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b0);
        drain();
        chk("t4_sat_third", sum_s, 2047);
        chk("t4_wrap_third", sum_w, 1015);

        // 5: ten back-to-back beats under 1,0,0 backpressure
        rmode = 1;
        nout = 0;
        for (int i = 0; i < 10; i++)
            send(8'(i * 7), 8'(i), 8'(200 - i), 8'(i * 3), 1'(i), 1'b0, 1'b0);
        drain();
        chk("t5_count", nout, 10);

        // random mix of modes, clears and backpressure
        rmode = 2;
        for (int i = 0; i < 60; i++) begin
            send(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                 1'($urandom), 1'($urandom), 1'($urandom % 4 == 0));
            if ($urandom % 4 == 0) begin
                in_valid = 1'b0;
                tick();
            end
        end
        drain();
        rmode = 0;
        tick();

        // 6: reset with two beats in flight and acc=50
        send(10, 10, 10, 10, 1'b0, 1'b1, 1'b1);
        send(5, 5, 0, 0, 1'b0, 1'b1, 1'b0);
        drain();
        rmode = 3;
        tick();
        send(1, 1, 1, 1, 1'b0, 1'b1, 1'b0);
        send(2, 2, 2, 2, 1'b0, 1'b1, 1'b0);
        in_valid = 1'b0;
        tick();
        chk("t6_full", in_ready_s, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_out_valid", out_valid_s, 0);
        chk("t6_sum", sum_s, 0);
        chk("t6_ovf", ovf_s, 0);
        chk("t6_wrap_ovf", ovf_w, 0);
        q.delete();
        m_acc_s = 0; m_acc_w = 0; m_ovf_s = 0; m_ovf_w = 0;
        armed = 0;
        stall_prev = 0;
        rmode = 0;
        out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        armed = 1;
        tick();
        chk("t6_no_pulse1", ov_s, 0);
        tick();
        chk("t6_no_pulse2", ov_s, 0);
        send(5, 0, 0, 0, 1'b0, 1'b1, 1'b0);
        drain();
        chk("t6_post_sum", sum_s, 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
